// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_ctrl
// Description : UART RX frame sequencer: oversampling edge/bit counters,
//               checker/deserializer enables and clean-frame data_valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic [5:0] PRESCALE,
    input  logic       PAR_EN,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic [5:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       dat_samp_en,
    output logic       strt_chk_en,
    output logic       deser_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       data_valid,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [3:0] c_LAST_DATA = 4'(DATA_WIDTH);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [5:0] r_edge_cnt;
    logic [5:0] w_edge_nxt;
    logic [3:0] r_bit_cnt;
    logic [3:0] w_bit_nxt;
    logic       r_par_en;
    logic       w_par_en_nxt;
    logic       r_chk_pend;
    logic       w_chk_pend_nxt;
    logic       w_bit_end;

    assign w_bit_end = (r_edge_cnt == PRESCALE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_edge_cnt <= 6'd0;
            r_bit_cnt  <= 4'd0;
            r_par_en   <= 1'b0;
            r_chk_pend <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_edge_cnt <= w_edge_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_par_en   <= w_par_en_nxt;
            r_chk_pend <= w_chk_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_par_en_nxt   = r_par_en;
        w_chk_pend_nxt = 1'b0;
        w_edge_nxt     = w_bit_end ? 6'd1 : r_edge_cnt + 6'd1;
        w_bit_nxt      = w_bit_end ? r_bit_cnt + 4'd1 : r_bit_cnt;
        case (r_state)
            S_IDLE: begin
                w_edge_nxt = 6'd0;
                w_bit_nxt  = 4'd0;
                if (!RX_IN) begin
                    w_state_nxt  = S_START;
                    w_edge_nxt   = 6'd1;
                    w_par_en_nxt = PAR_EN;
                end
            end
            S_START: begin
                if (w_bit_end) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                // Start checker result lands one cycle after the start bit ends
                if (r_bit_cnt == 4'd1 && r_edge_cnt == 6'd1 && strt_glitch) begin
                    w_state_nxt = S_IDLE;
                    w_edge_nxt  = 6'd0;
                    w_bit_nxt   = 4'd0;
                end else if (w_bit_end && r_bit_cnt == c_LAST_DATA) begin
                    w_state_nxt = r_par_en ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_bit_end) w_state_nxt = S_STOP;
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_chk_pend_nxt = 1'b1;
                    w_bit_nxt      = 4'd0;
                    if (!RX_IN) begin
                        w_state_nxt = S_START;
                        w_edge_nxt  = 6'd1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_edge_nxt  = 6'd0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_edge_nxt  = 6'd0;
                w_bit_nxt   = 4'd0;
            end
        endcase
    end

    always_comb begin
        dat_samp_en = 1'b0;
        strt_chk_en = 1'b0;
        deser_en    = 1'b0;
        par_chk_en  = 1'b0;
        stp_chk_en  = 1'b0;
        case (r_state)
            S_START: begin
                strt_chk_en = 1'b1;
                dat_samp_en = 1'b1;
            end
            S_DATA: begin
                dat_samp_en = 1'b1;
                deser_en    = 1'b1;
            end
            S_PARITY: begin
                par_chk_en  = 1'b1;
                dat_samp_en = 1'b1;
            end
            S_STOP: begin
                stp_chk_en  = 1'b1;
                dat_samp_en = 1'b1;
            end
            default: ;
        endcase
    end

    assign edge_cnt   = r_edge_cnt;
    assign bit_cnt    = r_bit_cnt;
    assign busy       = (r_state != S_IDLE);
    assign data_valid = r_chk_pend & ~stp_err & ~(r_par_en & par_err);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_ctrl
// Description : Scoreboard bench for uart_rx_ctrl with directed frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic [5:0] PRESCALE;
    logic       PAR_EN;
    logic       strt_glitch;
    logic       par_err;
    logic       stp_err;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       dat_samp_en;
    logic       strt_chk_en;
    logic       deser_en;
    logic       par_chk_en;
    logic       stp_chk_en;
    logic       data_valid;
    logic       busy;

    uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PRESCALE(PRESCALE), .PAR_EN(PAR_EN),
        .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
        .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .dat_samp_en(dat_samp_en),
        .strt_chk_en(strt_chk_en), .deser_en(deser_en), .par_chk_en(par_chk_en),
        .stp_chk_en(stp_chk_en), .data_valid(data_valid), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int exp_q[$];
    int dv_pulses = 0, last_dv = 0, prev_dv = 0;
    int deser_cnt = 0, par_cnt = 0, par_first = 0, busy_fall = 0;
    logic prev_busy = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: pop expected data_valid cycles whenever the DUT presents one
    always @(negedge CLK) begin
        if (!RST) begin
            if (data_valid) begin
                dv_pulses++;
                prev_dv = last_dv;
                last_dv = cyc;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL dv_unexpected: got pulse at %0d expected none", cyc);
                end else begin
                    chk("dv_cycle", cyc, exp_q.pop_front());
                end
            end
            if (deser_en) deser_cnt++;
            if (par_chk_en) begin
                if (par_cnt == 0) par_first = cyc;
                par_cnt++;
            end
            if (prev_busy && !busy) busy_fall = cyc;
            prev_busy = busy;
        end
    end

    function automatic int outs_word();
        return int'({edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en,
                     par_chk_en, stp_chk_en, data_valid, busy});
    endfunction

    // Drives one frame; t is the IDLE/STOP-last cycle in which the start low appears
    task automatic send_frame(input logic [7:0] d, input int p, input bit pe,
                              input bit perr, input bit serr, input bit b2b);
        int   t, nbits, len;
        logic bits [0:10];
        t        = cyc;
        nbits    = 10 + int'(pe);
        len      = nbits * p;
        PRESCALE = 6'(p);
        PAR_EN   = pe;
        bits[0]  = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        bits[9]  = pe ? ^d : 1'b1;
        bits[10] = 1'b1;
        fork
            begin
                repeat (len + 1) step();
                par_err = perr;
                stp_err = serr;
                step();
                par_err = 1'b0;
                stp_err = 1'b0;
            end
        join_none
        if (!(serr || (pe && perr))) exp_q.push_back(t + len + 1);
        for (int i = 0; i < nbits; i++) begin
            for (int k = 0; k < p; k++) begin
                if (b2b && i == 0 && k == 0) chk("edge_wrap_hi", int'(edge_cnt), p);
                if (i == 0 && k == 1) begin
                    chk("start_edge", int'(edge_cnt), 1);
                    chk("start_bit", int'(bit_cnt), 0);
                    chk("start_en", int'(strt_chk_en & dat_samp_en), 1);
                end
                RX_IN = (i == nbits - 1) ? 1'b1 : bits[i];
                step();
            end
        end
    endtask

    initial begin
        int t, dv0, hits;
        RST = 1'b1; RX_IN = 1'b1; PRESCALE = 6'd8; PAR_EN = 1'b0;
        strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        repeat (3) step();
        chk("reset_outs", outs_word(), 0);
        RST = 1'b0;
        repeat (3) step();
        chk("idle_outs", outs_word(), 0);

        // PRESCALE=8, no parity, clean frame
        deser_cnt = 0;
        t = cyc;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) step();
        chk("deser_len", deser_cnt, 64);
        chk("busy_fall", busy_fall, t + 81);

        // PRESCALE=16, parity with parity error
        par_cnt = 0; dv0 = dv_pulses;
        t = cyc;
        send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (5) step();
        chk("par_err_no_dv", dv_pulses - dv0, 0);
        chk("par_first", par_first, t + 145);
        chk("par_len", par_cnt, 16);

        // false start: low two cycles, glitch reported in first DATA cycle
        PRESCALE = 6'd8; PAR_EN = 1'b0; dv0 = dv_pulses;
        t = cyc;
        RX_IN = 1'b0;
        step(); step();
        RX_IN = 1'b1;
        repeat (7) step();
        strt_glitch = 1'b1;
        chk("glitch_pre_cycle", cyc, t + 9);
        chk("glitch_pre_state", int'({busy, bit_cnt, edge_cnt}), int'({1'b1, 4'd1, 6'd1}));
        step();
        strt_glitch = 1'b0;
        chk("glitch_idle", outs_word(), 0);
        repeat (3) step();
        chk("glitch_no_dv", dv_pulses - dv0, 0);

        // stop error, then a clean frame
        dv0 = dv_pulses;
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) step();
        chk("stp_err_no_dv", dv_pulses - dv0, 0);
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) step();

        // PRESCALE=32, back-to-back frames
        send_frame(8'h11, 32, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'hEE, 32, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (5) step();
        chk("b2b_spacing", last_dv - prev_dv, 320);

        // asynchronous reset mid-DATA
        PRESCALE = 6'd8; dv0 = dv_pulses;
        RX_IN = 1'b0;
        step();
        RX_IN = 1'b1;
        hits = 0;
        while (bit_cnt != 4'd4 && hits < 200) begin
            step();
            hits++;
        end
        chk("reach_bit4", int'(bit_cnt), 4);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("async_reset_outs", outs_word(), 0);
        step(); step();
        @(negedge CLK);
        RST = 1'b0;
        hits = 0;
        repeat (40) begin
            step();
            if (busy) hits++;
        end
        chk("post_reset_idle", hits, 0);
        chk("reset_no_dv", dv_pulses - dv0, 0);
        send_frame(8'h96, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) step();

        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
